sa_drain: RTL and testbench
===========================

SA_DRAIN -- requirements
Module: sa_drain

Interface
REQ-001 Parameter N, default 8: width of one matrix element in bits.
REQ-002 Parameter SIZE, default 4: array dimension; the array has SIZE rows and SIZE columns.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rstn  input  1: reset, synchronous, active-low.
REQ-005 start  input  1: single-cycle request to unload the finished array results.
REQ-006 c_in  input  SIZE*N: C output of the last PE of each row; row r occupies bits [r*N +: N].
REQ-007 output_sign  output  1: OutputSign drive to every PE; 1 selects shift mode (C passes along the row).
REQ-008 out_data  output  SIZE*N: one result-matrix row per beat; column c occupies bits [c*N +: N].
REQ-009 out_valid  output  1: out_data holds a valid row.
REQ-010 out_ready  input  1: downstream accepts the beat.
REQ-011 out_last  output  1: the current beat is row SIZE-1.
REQ-012 busy  output  1: high in any state other than IDLE.

Function
REQ-013 The block SHALL implement three states: IDLE, SHIFT and SEND.
REQ-014 IDLE -> SHIFT on a clock edge with start=1; start SHALL be ignored in SHIFT and SEND.
REQ-015 output_sign SHALL be 1 exactly while in SHIFT (decoded from the registered state) and 0 otherwise.
REQ-016 SHIFT lasts exactly SIZE cycles, counted by a shift counter k = 0..SIZE-1.
- On each SHIFT edge, for every row r, the block SHALL capture c_in row r into buffer[r][SIZE-1-k].
- k=0 captures the column SIZE-1 result already held by the last PE.
REQ-017 SHIFT -> SEND on the edge where k=SIZE-1; row counter j is cleared to 0.
REQ-018 In SEND, out_valid=1 and out_data = buffer[j]; out_last=1 when j=SIZE-1.
REQ-019 A beat transfers on an edge with out_valid=1 and out_ready=1; j then increments.
REQ-020 Transfer with out_last=1 SHALL return to IDLE; out_valid SHALL be 0 in the following cycle.
REQ-021 Backpressure: while out_ready=0 in SEND, out_data, out_valid and out_last SHALL hold stable.
REQ-022 Arithmetic: buffer entries are N bits, copied verbatim with no truncation or extension; counters wrap only via the state transitions above.
REQ-023 Total latency from start to the first valid beat SHALL be SIZE+1 cycles; with out_ready tied to 1, a full unload occupies 2*SIZE+1 cycles from start to return to IDLE.
REQ-024 Buffer contents SHALL persist in IDLE until the next SHIFT overwrites them.

Reset
REQ-025 rstn=0 at a clock edge SHALL force state=IDLE, k=0 and j=0; on the following cycle output_sign, out_valid, out_last and busy SHALL be 0.
REQ-026 Reset SHALL clear all buffer entries to 0.
REQ-027 Reset asserted during SHIFT or SEND SHALL abort the unload immediately; no further beats are emitted and the partial data is discarded.
REQ-028 start asserted in the same cycle as rstn=0 SHALL be ignored.

Verification
REQ-029 Basic unload (SIZE=4, N=8, out_ready=1):
- Stimulus: drive c_in so that row r presents 16*r+3, 16*r+2, 16*r+1, 16*r+0 over the four SHIFT cycles.
- Required response: output_sign high for exactly 4 cycles; beats 0x03020100, 0x13121110, 0x23222120, 0x33323130; out_last only on beat 3.
REQ-030 Backpressure: out_ready=0 for 5 cycles at beat 1, then out_ready=1.
- Required response: beat 1 value held unchanged for 6 cycles; all 4 beats delivered once each, in order.
REQ-031 start ignored when busy: pulse start during SHIFT and during SEND.
- Required response: the sequence is identical to REQ-029 and no second SHIFT occurs.
REQ-032 Reset mid-operation: rstn=0 for 1 cycle at SHIFT k=2.
- Required response: next cycle shows state IDLE, output_sign=0, out_valid=0.
- A following start produces a clean 4-beat unload.
REQ-033 Back-to-back: issue start in the cycle after the last transfer.
- Required response: SHIFT begins on that edge, and the first beat of the second unload appears SIZE+1 cycles later.
REQ-034 Overflow-width data: all c_in elements = 0xFF.
- Required response: every beat = 0xFFFFFFFF with no bleed between fields.

Source files
------------

// File: rtl/sa_drain_if.sv
// sa_drain_if
// Result stream from the systolic-array drain unit: one result-matrix row
// per beat with a valid/ready handshake.
//   out_data  : SIZE*N  one matrix row, column c at bits [c*N +: N]
//   out_valid : 1       out_data holds a valid row
//   out_ready : 1       downstream accepts the beat
//   out_last  : 1       the current beat is the final row (SIZE-1)
// Modports: master = drain unit (produces rows), slave = downstream consumer.
interface sa_drain_if #(
  parameter int N    = 8,
  parameter int SIZE = 4
);
  logic [SIZE*N-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sa_drain.sv
// sa_drain
// Unloads the finished C results from a SIZE x SIZE systolic array. The array
// is put into shift mode for SIZE cycles while the C value leaving the last PE
// of each row is captured into a local buffer, then the buffer is streamed out
// one row per beat over a valid/ready handshake.
// Ports:
//   clk         : clock, all state updates on the rising edge
//   rstn        : synchronous active-low reset
//   start       : single-cycle unload request (only honoured in IDLE)
//   c_in        : SIZE*N, C output of the last PE of row r at bits [r*N +: N]
//   output_sign : high while the array shifts C along its rows
//   busy        : high whenever the unit is not IDLE
//   dout        : result stream (sa_drain_if master modport)
module sa_drain #(
  parameter int N    = 8,
  parameter int SIZE = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [SIZE*N-1:0] c_in,
  output logic              output_sign,
  output logic              busy,
  sa_drain_if.master        dout
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] k;
  logic [CW-1:0] j;
  logic [N-1:0]  buffer [SIZE][SIZE];

  // Main FSM. During SHIFT the value arriving on shift k belongs to column
  // SIZE-1-k, because the last PE already holds the rightmost column when
  // shifting begins and each shift brings the next column to the left.
  // In SEND the row pointer j only advances on an accepted beat, so the
  // presented row stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      k     <= '0;
      j     <= '0;
      for (int r = 0; r < SIZE; r++) begin
        for (int c = 0; c < SIZE; c++) begin
          buffer[r][c] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            k     <= '0;
          end
        end
        SHIFT: begin
          for (int r = 0; r < SIZE; r++) begin
            buffer[r][LAST - k] <= c_in[r*N +: N];
          end
          if (k == LAST) begin
            state <= SEND;
            k     <= '0;
            j     <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        SEND: begin
          if (dout.out_ready) begin
            if (j == LAST) begin
              state <= IDLE;
              j     <= '0;
            end else begin
              j <= j + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          k     <= '0;
          j     <= '0;
        end
      endcase
    end
  end

  // Status and handshake outputs are decoded purely from registered state,
  // so none of them has a combinational path from an input.
  assign output_sign    = (state == SHIFT);
  assign busy           = (state != IDLE);
  assign dout.out_valid = (state == SEND);
  assign dout.out_last  = (state == SEND) && (j == LAST);

  // Present buffer row j, column c in field c of the output word.
  always_comb begin
    dout.out_data = '0;
    for (int c = 0; c < SIZE; c++) begin
      dout.out_data[c*N +: N] = buffer[j][c];
    end
  end

endmodule

// File: tb/tb_sa_drain.sv
// tb_sa_drain
// Scoreboard bench for sa_drain (SIZE=4, N=8). Stimulus pushes the expected
// beats into a queue; an independent monitor pops and compares every beat
// that transfers on the output stream.
module tb_sa_drain;
  localparam int N    = 8;
  localparam int SIZE = 4;

  typedef struct packed {
    logic [SIZE*N-1:0] data;
    logic              last;
  } beat_t;

  logic              clk   = 1'b0;
  logic              rstn  = 1'b0;
  logic              start = 1'b0;
  logic [SIZE*N-1:0] c_in  = '0;
  logic              output_sign;
  logic              busy;

  beat_t sb[$];
  int    checks = 0;
  int    passes = 0;

  sa_drain_if #(.N(N), .SIZE(SIZE)) dif ();

  sa_drain #(.N(N), .SIZE(SIZE)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .c_in        (c_in),
    .output_sign (output_sign),
    .busy        (busy),
    .dout        (dif)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Value presented by row r on shift k: mode 0 is the 16*r+3-k ramp,
  // mode 1 is all ones in every element.
  function automatic logic [SIZE*N-1:0] pattern(input int mode, input int k);
    logic [SIZE*N-1:0] v;
    v = '0;
    for (int r = 0; r < SIZE; r++) begin
      if (mode == 1) v[r*N +: N] = 8'hFF;
      else           v[r*N +: N] = 8'(16*r + 3 - k);
    end
    return v;
  endfunction

  // Hand-computed expected beats for each stimulus mode
  task automatic pushRows(input int mode);
    beat_t b;
    logic [31:0] ramp [4];
    ramp[0] = 32'h03020100;
    ramp[1] = 32'h13121110;
    ramp[2] = 32'h23222120;
    ramp[3] = 32'h33323130;
    for (int i = 0; i < 4; i++) begin
      b.data = (mode == 1) ? 32'hFFFFFFFF : ramp[i];
      b.last = (i == 3);
      sb.push_back(b);
    end
  endtask

  // One complete unload starting from IDLE. pokeStart pulses start during
  // SHIFT and SEND; backPressure stalls beat 1 for 5 cycles.
  task automatic applyStimulus(input int mode, input bit pokeStart, input bit backPressure);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      c_in = pattern(mode, k);
      checkOutput("sign_in_shift", output_sign, 1);
      checkOutput("valid_in_shift", dif.out_valid, 0);
      if (pokeStart && k == 1) start = 1'b1;
      tick();
      start = 1'b0;
    end
    checkOutput("first_beat_latency", dif.out_valid, 1);
    checkOutput("sign_after_shift", output_sign, 0);
    cyc = 0;
    if (pokeStart) start = 1'b1;
    if (backPressure) begin
      tick();
      start = 1'b0;
      cyc++;
      dif.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
        checkOutput("bp_hold_data", dif.out_data, 32'h13121110);
        checkOutput("bp_hold_valid", dif.out_valid, 1);
        checkOutput("bp_hold_last", dif.out_last, 0);
        if (i == 5) dif.out_ready = 1'b1;
        tick();
        cyc++;
      end
    end
    while (busy && cyc < 50) begin
      tick();
      start = 1'b0;
      cyc++;
    end
    start = 1'b0;
    checkOutput("drain_timeout", busy, 0);
    checkOutput("valid_after_last", dif.out_valid, 0);
    if (!backPressure) checkOutput("send_cycles", cyc, SIZE);
  endtask

  // Monitor: compare every transferred beat against the scoreboard
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rstn && dif.out_valid && dif.out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_beat", dif.out_data, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("beat_data", dif.out_data, e.data);
        checkOutput("beat_last", dif.out_last, e.last);
      end
    end
  end

  initial begin
    dif.out_ready = 1'b1;
    rstn = 1'b0;
    tick();
    tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sign", output_sign, 0);
    checkOutput("reset_valid", dif.out_valid, 0);
    checkOutput("reset_last", dif.out_last, 0);
    rstn = 1'b1;
    tick();

    $display("[TB] basic unload");
    pushRows(0);
    applyStimulus(0, 1'b0, 1'b0);
    tick();

    $display("[TB] backpressure on beat 1");
    pushRows(0);
    applyStimulus(0, 1'b0, 1'b1);
    tick();

    $display("[TB] start ignored while busy");
    pushRows(0);
    applyStimulus(0, 1'b1, 1'b0);
    tick();
    checkOutput("no_second_shift", output_sign, 0);
    checkOutput("idle_after_poke", busy, 0);

    $display("[TB] reset at shift k=2");
    start = 1'b1;
    tick();
    start = 1'b0;
    c_in = pattern(0, 0);
    tick();
    c_in = pattern(0, 1);
    tick();
    rstn  = 1'b0;
    start = 1'b1;
    tick();
    rstn  = 1'b0;
    start = 1'b0;
    rstn  = 1'b1;
    checkOutput("abort_sign", output_sign, 0);
    checkOutput("abort_valid", dif.out_valid, 0);
    checkOutput("abort_busy", busy, 0);
    tick();
    checkOutput("start_in_reset_ignored", busy, 0);
    pushRows(0);
    applyStimulus(0, 1'b0, 1'b0);

    $display("[TB] back-to-back unloads, all-ones data");
    pushRows(0);
    applyStimulus(0, 1'b0, 1'b0);
    pushRows(1);
    applyStimulus(1, 1'b0, 1'b0);
    tick();
    tick();

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
